// File: rtl/simd_shift_pipe.sv
// Two-stage SIMD shift/rotate unit (SLL, SRL, SRA, ROL) on 8..SIMD_WIDTH-bit lanes.
// Operands and results use valid/ready handshakes, and the pipeline stalls as a whole under back-pressure.
module simd_shift_pipe #(
    parameter int SIMD_WIDTH = 256,
    parameter int MODE_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD_WIDTH-1:0] A,
    input  logic [SIMD_WIDTH-1:0] B,
    input  logic [MODE_W-1:0]     data_mode,
    input  logic [1:0]            sel,
    input  logic                  imm_flag,
    input  logic [7:0]            imm_reg,
    input  logic                  per_lane,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] out
);

    localparam int LOG2W  = $clog2(SIMD_WIDTH);
    localparam int NMODES = LOG2W - 2;
    localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NMODES - 1);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_SLL = 2'b11;

    logic                  s1_valid_r;
    logic                  s2_valid_r;
    logic                  s1_adv_s;
    logic                  s2_adv_s;
    logic [SIMD_WIDTH-1:0] a_r;
    logic [SIMD_WIDTH-1:0] b_r;
    logic [MODE_W-1:0]     mode_r;
    logic [1:0]            sel_r;
    logic                  per_lane_r;
    logic [7:0]            amt_r;
    logic [MODE_W-1:0]     mode_eff_s;
    logic [7:0]            amt_s;
    logic [SIMD_WIDTH-1:0] result_s;
    logic [SIMD_WIDTH-1:0] out_r;
    logic [SIMD_WIDTH-1:0] mode_res_s [NMODES];
    logic                  unused_s;

    assign s2_adv_s  = !s2_valid_r || out_ready;
    assign s1_adv_s  = !s1_valid_r || s2_adv_s;
    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_r;
    assign out       = out_r;

    // Resolve lane size (clamped to full width) and the scalar amount source.
    always_comb begin
        mode_eff_s = data_mode;
        amt_s      = B[7:0];
        if (data_mode > MAX_MODE) begin
            mode_eff_s = MAX_MODE;
        end else begin
            mode_eff_s = data_mode;
        end
        if (imm_flag) begin
            amt_s = imm_reg;
        end else begin
            amt_s = B[7:0];
        end
    end

    // Stage 1 valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 1 operand capture, only on an accepted beat.
    always_ff @(posedge clk) begin
        if (s1_adv_s && in_valid) begin
            a_r        <= A;
            b_r        <= B;
            mode_r     <= mode_eff_s;
            sel_r      <= sel;
            per_lane_r <= per_lane;
            amt_r      <= amt_s;
        end
    end

    // One full-width result per lane size; the mode mux below picks one.
    for (genvar k = 0; k < NMODES; k++) begin : g_mode
        localparam int LW  = 8 << k;
        localparam int NL  = SIMD_WIDTH / LW;
        localparam int AWK = ($clog2(LW) > 8) ? 8 : $clog2(LW);
        logic [SIMD_WIDTH-1:0] res_s;

        for (genvar i = 0; i < NL; i++) begin : g_lane
            logic [LW-1:0]  x_s;
            logic [LW-1:0]  y_s;
            logic [AWK-1:0] n_s;

            assign x_s = a_r[i*LW +: LW];
            assign n_s = per_lane_r ? b_r[i*LW +: AWK] : amt_r[AWK-1:0];

            // Per-lane shifter; shifts are confined to the LW-bit lane vector.
            always_comb begin
                y_s = x_s;
                case (sel_r)
                    OP_SLL: y_s = x_s << n_s;
                    OP_SRL: y_s = x_s >> n_s;
                    OP_SRA: y_s = $unsigned($signed(x_s) >>> n_s);
                    OP_ROL: begin
                        if (n_s == '0) begin
                            y_s = x_s;
                        end else begin
                            y_s = (x_s << n_s) | (x_s >> (LW - int'(n_s)));
                        end
                    end
                    default: y_s = x_s;
                endcase
            end

            assign res_s[i*LW +: LW] = y_s;
        end

        assign mode_res_s[k] = res_s;
    end

    // One-hot AND-OR select of the result for the registered lane size.
    always_comb begin
        result_s = '0;
        for (int k = 0; k < NMODES; k++) begin
            result_s = result_s | (mode_res_s[k] & {SIMD_WIDTH{mode_r == MODE_W'(k)}});
        end
    end

    // Stage 2: result register and output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            out_r      <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_r <= result_s;
            end else begin
                out_r <= out_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
            out_r      <= out_r;
        end
    end

    // Upper bits of each B lane carry no amount.
    assign unused_s = ^{b_r, amt_r};

endmodule

// File: tb/tb_simd_shift_pipe.sv
// Self-checking bench for simd_shift_pipe: directed vector table, back-pressure and reset
// sequences, and randomized traffic scored against a bit-level reference model.
module tb_simd_shift_pipe;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   data_mode;
    logic [1:0]   sel;
    logic         imm_flag;
    logic [7:0]   imm_reg;
    logic         per_lane;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int emit_count = 0;
    logic [W-1:0] sbq[$];
    int emit_cyc[$];

    simd_shift_pipe #(.SIMD_WIDTH(W), .MODE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .data_mode(data_mode), .sel(sel), .imm_flag(imm_flag),
        .imm_reg(imm_reg), .per_lane(per_lane), .out_valid(out_valid),
        .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: every result bit is picked from its source bit inside the same lane.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int mode, input logic [1:0] op,
                                           input logic imf, input logic [7:0] imm,
                                           input logic pl);
        logic [W-1:0] r;
        int lw;
        int aw;
        int n;
        int src;
        r  = '0;
        lw = (mode > 20) ? W : (8 << mode);
        if (lw > W) lw = W;
        aw = $clog2(lw);
        if (aw > 8) aw = 8;
        for (int base = 0; base < W; base += lw) begin
            if (pl) begin
                n = 0;
                for (int k = 0; k < aw; k++) n += int'(b[base+k]) << k;
            end else begin
                src = imf ? int'(imm) : int'(b[7:0]);
                n   = src % (1 << aw);
            end
            for (int j = 0; j < lw; j++) begin
                case (op)
                    2'b11: r[base+j] = (j >= n) ? a[base+j-n] : 1'b0;
                    2'b00: r[base+j] = (j + n < lw) ? a[base+j+n] : 1'b0;
                    2'b01: r[base+j] = (j + n < lw) ? a[base+j+n] : a[base+lw-1];
                    default: r[base+j] = a[base + ((j - n + lw) % lw)];
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: check emitted results in order, queue the model result of each accepted beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_emit", W'(1), W'(0));
                end else begin
                    chk("scoreboard", out, sbq.pop_front());
                end
                emit_count++;
                emit_cyc.push_back(cyc);
            end
            if (in_valid && in_ready)
                sbq.push_back(model(A, B, int'(data_mode), sel, imm_flag, imm_reg, per_lane));
        end
    end

    // Present one beat at posedge+1, hold until accepted, then scramble the inputs.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                        input logic [1:0] op, input logic imf, input logic [7:0] imm,
                        input logic pl);
        bit ok;
        A = a; B = b; data_mode = m; sel = op; imm_flag = imf; imm_reg = imm; per_lane = pl;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", W'(0), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = rand_w(); B = rand_w(); data_mode = 3'($urandom); sel = 2'($urandom);
        imm_flag = 1'($urandom); imm_reg = 8'($urandom); per_lane = 1'($urandom);
    endtask

    typedef struct {
        string        name;
        logic [2:0]   mode;
        logic [1:0]   op;
        logic         imf;
        logic [7:0]   imm;
        logic         pl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[8];
    bit   done;
    int   base_emit;
    int   base_idx;
    logic [W-1:0] held;

    initial begin
        vecs[0] = '{"sra8_imm3", 3'd0, 2'b01, 1'b1, 8'd3, 1'b0, {32{8'h80}},
                    {8{32'hDEADBEEF}}, {32{8'hF0}}};
        vecs[1] = '{"rol16_b11", 3'd1, 2'b10, 1'b0, 8'h05, 1'b0, {16{16'h8001}},
                    {{(W-8){1'b0}}, 8'h11}, {16{16'h0003}}};
        vecs[2] = '{"srl16_b11", 3'd1, 2'b00, 1'b0, 8'h05, 1'b0, {16{16'h8001}},
                    {{(W-8){1'b0}}, 8'h11}, {16{16'h4000}}};
        vecs[3] = '{"sll32_lane", 3'd2, 2'b11, 1'b1, 8'd4, 1'b1, {8{32'h00000001}},
                    {2{32'd32, 32'd31, 32'd1, 32'd0}},
                    {2{32'h00000001, 32'h80000000, 32'h00000002, 32'h00000001}}};
        vecs[4] = '{"sra256_m5", 3'd5, 2'b01, 1'b1, 8'hFF, 1'b0, {1'b1, {(W-1){1'b0}}},
                    {W{1'b0}}, {W{1'b1}}};
        vecs[5] = '{"sra256_m6", 3'd6, 2'b01, 1'b1, 8'hFF, 1'b0, {1'b1, {(W-1){1'b0}}},
                    {W{1'b0}}, {W{1'b1}}};
        vecs[6] = '{"sra256_m7", 3'd7, 2'b01, 1'b1, 8'hFF, 1'b0, {1'b1, {(W-1){1'b0}}},
                    {W{1'b0}}, {W{1'b1}}};
        vecs[7] = '{"rol64_b48", 3'd3, 2'b10, 1'b0, 8'h00, 1'b0, {4{64'h0123456789ABCDEF}},
                    {{(W-8){1'b0}}, 8'h48}, {4{64'h23456789ABCDEF01}}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; data_mode = 3'd0; sel = 2'b00; imm_flag = 1'b0; imm_reg = 8'd0;
        per_lane = 1'b0;
        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out", out, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table with two-cycle latency check.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].a, vecs[v].b, vecs[v].mode, vecs[v].op, vecs[v].imf, vecs[v].imm,
                 vecs[v].pl);
            @(negedge clk);
            chk({vecs[v].name, "_early"}, W'(out_valid), W'(0));
            @(negedge clk);
            chk({vecs[v].name, "_valid"}, W'(out_valid), W'(1));
            chk(vecs[v].name, out, vecs[v].exp);
            @(posedge clk);
            #1;
        end

        // Back-pressure: 4 back-to-back beats, out_ready low for 5 cycles.
        base_idx = emit_cyc.size();
        base_emit = emit_count;
        done = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(rand_w(), rand_w(), 3'($urandom_range(0, 7)), 2'($urandom),
                         1'($urandom), 8'($urandom), 1'($urandom));
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (c == 2) held = out;
                    if (c >= 2) begin
                        chk("stall_in_ready", W'(in_ready), W'(0));
                        chk("stall_out_valid", W'(out_valid), W'(1));
                        chk("stall_hold", out, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 60 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        chk("bp_count", W'(emit_count - base_emit), W'(4));
        if (emit_cyc.size() >= base_idx + 4)
            for (int k = 0; k < 3; k++)
                chk("bp_back_to_back", W'(emit_cyc[base_idx+k+1] - emit_cyc[base_idx+k]), W'(1));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(rand_w(), rand_w(), 3'd0, 2'b11, 1'b0, 8'd0, 1'b0);
        send(rand_w(), rand_w(), 3'd1, 2'b10, 1'b0, 8'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_out", out, '0);
        chk("midrst_in_ready", W'(in_ready), W'(1));
        sbq.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        base_emit = emit_count;
        send({32{8'h81}}, {W{1'b0}}, 3'd0, 2'b11, 1'b1, 8'd1, 1'b0);
        @(negedge clk);
        chk("postrst_early", W'(out_valid), W'(0));
        @(negedge clk);
        chk("postrst_valid", W'(out_valid), W'(1));
        chk("postrst_out", out, {32{8'h02}});
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_count", W'(emit_count - base_emit), W'(1));

        // Randomized traffic with random back-pressure.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(rand_w(), rand_w(), 3'($urandom_range(0, 7)), 2'($urandom),
                         1'($urandom), 8'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 60 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", W'(sbq.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
